// File: rtl/seg7_pkg.sv
// Shared types and constants for the seven-segment display arbiter.
package seg7_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GNT_CPU = 2'd1,
        GNT_DBG = 2'd2
    } arb_state_e;

    localparam logic ADDR_DATA = 1'b0;
    localparam logic ADDR_CFG  = 1'b1;

    localparam int unsigned EN_LSB    = 0;
    localparam int unsigned BLINK_LSB = 6;

    localparam logic [5:0] DIGIT_EN_RST = 6'h3F;

    localparam logic SRC_CPU = 1'b0;
    localparam logic SRC_DBG = 1'b1;

endpackage

// File: rtl/seg7_blink_timer.sv
// Blink prescaler: toggles phase every BLINK_DIV cycles; clr restarts
// the count in the visible phase and wins over the wrap.
module seg7_blink_timer #(
    parameter int unsigned BLINK_DIV = 25000000,
    parameter int unsigned CNT_W     = 25
) (
    input  logic m_clock,
    input  logic rst_n,
    input  logic clr,
    output logic phase
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(BLINK_DIV - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             phase_q, phase_d;

    always_comb begin
        cnt_d   = cnt_q + CNT_W'(1);
        phase_d = phase_q;
        if (clr) begin
            cnt_d   = '0;
            phase_d = 1'b0;
        end else if (cnt_q == CNT_MAX) begin
            cnt_d   = '0;
            phase_d = ~phase_q;
        end
    end

    always_ff @(posedge m_clock or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q   <= '0;
            phase_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            phase_q <= phase_d;
        end
    end

    assign phase = phase_q;

endmodule

// File: rtl/seg7_disp_arb.sv
// Round-robin arbiter sharing the 6-digit display between CPU and debug,
// holding display data, digit enable / blink config and the blank mask.
module seg7_disp_arb
    import seg7_pkg::*;
#(
    parameter int unsigned BLINK_DIV = 25000000,
    parameter int unsigned CNT_W     = 25
) (
    input  logic        m_clock,
    input  logic        rst_n,
    input  logic        cpu_req,
    input  logic        cpu_addr,
    input  logic [31:0] cpu_wdata,
    output logic        cpu_ack,
    input  logic        dbg_req,
    input  logic [31:0] dbg_wdata,
    output logic        dbg_ack,
    input  logic        dbg_lock,
    output logic [31:0] disp_data,
    output logic [5:0]  disp_blank,
    output logic        disp_src
);

    arb_state_e  state_q, state_d;
    logic        last_grant_q, last_grant_d;
    logic [31:0] disp_data_q, disp_data_d;
    logic        disp_src_q, disp_src_d;
    logic [5:0]  digit_en_q, digit_en_d;
    logic [5:0]  blink_mask_q, blink_mask_d;
    logic [5:0]  blank_q, blank_d;

    logic cpu_elig;
    logic dbg_elig;
    logic cfg_clr;
    logic blink_phase;

    assign cpu_elig = cpu_req & ~dbg_lock;
    assign dbg_elig = dbg_req;
    assign cfg_clr  = (state_q == GNT_CPU) && (cpu_addr == ADDR_CFG);

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        disp_data_d  = disp_data_q;
        disp_src_d   = disp_src_q;
        digit_en_d   = digit_en_q;
        blink_mask_d = blink_mask_q;
        unique case (state_q)
            IDLE: begin
                if (cpu_elig && dbg_elig) begin
                    state_d = (last_grant_q == SRC_DBG) ? GNT_CPU : GNT_DBG;
                end else if (cpu_elig) begin
                    state_d = GNT_CPU;
                end else if (dbg_elig) begin
                    state_d = GNT_DBG;
                end
            end
            GNT_CPU: begin
                state_d      = IDLE;
                last_grant_d = SRC_CPU;
                if (cpu_addr == ADDR_CFG) begin
                    digit_en_d   = cpu_wdata[EN_LSB+:6];
                    blink_mask_d = cpu_wdata[BLINK_LSB+:6];
                end else begin
                    disp_data_d = cpu_wdata;
                    disp_src_d  = SRC_CPU;
                end
            end
            GNT_DBG: begin
                state_d      = IDLE;
                last_grant_d = SRC_DBG;
                disp_data_d  = dbg_wdata;
                disp_src_d   = SRC_DBG;
            end
            default: state_d = IDLE;
        endcase
    end

    // Mask is built from registered sources, so it trails them by a cycle.
    always_comb begin
        blank_d = ~digit_en_q | (blink_mask_q & {6{blink_phase}});
    end

    always_ff @(posedge m_clock or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            last_grant_q <= SRC_DBG;
            disp_data_q  <= '0;
            disp_src_q   <= SRC_CPU;
            digit_en_q   <= DIGIT_EN_RST;
            blink_mask_q <= '0;
            blank_q      <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            disp_data_q  <= disp_data_d;
            disp_src_q   <= disp_src_d;
            digit_en_q   <= digit_en_d;
            blink_mask_q <= blink_mask_d;
            blank_q      <= blank_d;
        end
    end

    seg7_blink_timer #(
        .BLINK_DIV (BLINK_DIV),
        .CNT_W     (CNT_W)
    ) u_blink (
        .m_clock (m_clock),
        .rst_n   (rst_n),
        .clr     (cfg_clr),
        .phase   (blink_phase)
    );

    assign cpu_ack    = (state_q == GNT_CPU);
    assign dbg_ack    = (state_q == GNT_DBG);
    assign disp_data  = disp_data_q;
    assign disp_src   = disp_src_q;
    assign disp_blank = blank_q;

endmodule
